// File: rtl/aes_key_schedule_pkg.sv
// Shared definitions for the AES key-schedule engine.
//   nk(key_bits) : key length in 32-bit words
//   nr(key_bits) : number of cipher rounds
//   xtime(b)     : GF(2^8) multiply-by-x, used to step rcon
//   state_t      : controller state encoding
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        OUTPUT
    } state_t;

    function automatic int nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_sbox.sv
// AES forward S-box, purely combinational lookup.
//   data_in  : byte to substitute
//   data_out : S-box image of data_in
module aes_sbox (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // Entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_out = SBOX[data_in];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key-schedule engine (128/192/256-bit keys).
// Expands the loaded key one word per cycle into a word buffer, then streams
// round keys over a valid/ready handshake, ascending or descending.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load request (IDLE only); key_in / inv_mode sampled with it
//   busy      : high outside IDLE
//   rk_valid / rk_ready / rk_data / rk_round : round-key stream
//   done      : one-cycle pulse after the final round-key handshake
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                inv_mode,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_round,
    output logic                done
);

    localparam int NK    = nk(KEY_BITS);
    localparam int NR    = nr(KEY_BITS);
    localparam int WORDS = 4 * (NR + 1);

    localparam logic [5:0] LAST_IDX   = 6'(WORDS - 1);
    localparam logic [5:0] NK_W       = 6'(NK);
    localparam logic [2:0] NK_M1      = 3'(NK - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    state_t       state_q, state_d;
    logic [31:0]  w_q [WORDS];
    logic [5:0]   idx_q;
    logic [2:0]   phase_q;      // idx_q mod NK, kept as a counter
    logic [7:0]   rcon_q;
    logic         inv_q;
    logic         rk_valid_q;
    logic [127:0] rk_data_q;
    logic [3:0]   rk_round_q;
    logic         done_q;

    logic [31:0]  prev_word, old_word, sbox_in, sub_word, temp_word, new_word;
    logic         hs, last_hs;
    logic [3:0]   round_next;
    logic [5:0]   rd_base;
    logic [127:0] rd_data;

    // ---------------- expansion datapath ----------------
    assign prev_word = w_q[idx_q - 6'd1];
    assign old_word  = w_q[idx_q - NK_W];
    assign sbox_in   = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data_in  (sbox_in[8*b +: 8]),
            .data_out (sub_word[8*b +: 8])
        );
    end

    always_comb begin
        temp_word = prev_word;
        if (phase_q == 3'd0) begin
            temp_word = sub_word ^ {rcon_q, 24'h0};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp_word = sub_word;
        end
    end

    assign new_word = old_word ^ temp_word;

    // ---------------- output read path ----------------
    assign hs         = (state_q == OUTPUT) && rk_valid_q && rk_ready;
    assign last_hs    = hs && (rk_round_q == (inv_q ? 4'd0 : LAST_ROUND));
    assign round_next = inv_q ? rk_round_q - 4'd1 : rk_round_q + 4'd1;

    // On the EXPAND->OUTPUT edge the last word is still being written, so an
    // inverse stream takes its fourth word from the expansion result directly.
    always_comb begin
        rd_base = {round_next, 2'b00};
        if (state_q == EXPAND) begin
            rd_base = inv_q ? {LAST_ROUND, 2'b00} : 6'd0;
        end
        rd_data = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2],
                   (state_q == EXPAND && inv_q) ? new_word : w_q[rd_base + 6'd3]};
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)              state_d = EXPAND;
            EXPAND:  if (idx_q == LAST_IDX)  state_d = OUTPUT;
            OUTPUT:  if (last_hs)            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // ---------------- control / output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            phase_q    <= '0;
            rcon_q     <= '0;
            inv_q      <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_round_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= NK_W;
                        phase_q <= '0;
                        rcon_q  <= 8'h01;
                        inv_q   <= inv_mode;
                    end
                end
                EXPAND: begin
                    idx_q   <= idx_q + 6'd1;
                    phase_q <= (phase_q == NK_M1) ? 3'd0 : phase_q + 3'd1;
                    if (phase_q == 3'd0) rcon_q <= xtime(rcon_q);
                    if (idx_q == LAST_IDX) begin
                        rk_valid_q <= 1'b1;
                        rk_data_q  <= rd_data;
                        rk_round_q <= inv_q ? LAST_ROUND : 4'd0;
                    end
                end
                OUTPUT: begin
                    if (last_hs) begin
                        rk_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (hs) begin
                        rk_data_q  <= rd_data;
                        rk_round_q <= round_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word buffer: plain registers, never cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == IDLE && start) begin
                for (int unsigned k = 0; k < NK; k++) begin
                    w_q[6'(k)] <= key_in[KEY_BITS - 1 - 32 * int'(k) -: 32];
                end
            end else if (state_q == EXPAND) begin
                w_q[idx_q] <= new_word;
            end
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_round = rk_round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

    logic         clk;
    logic         rst_v      [3];
    logic         start_v    [3];
    logic         inv_v      [3];
    logic         rk_ready_v [3];
    logic [255:0] key_r      [3];
    logic         busy_v     [3];
    logic         rk_valid_v [3];
    logic         done_v     [3];
    logic [127:0] rk_data_v  [3];
    logic [3:0]   rk_round_v [3];

    aes_key_schedule #(.KEY_BITS(128)) u_k128 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .key_in(key_r[0][255:128]),
        .inv_mode(inv_v[0]), .busy(busy_v[0]), .rk_valid(rk_valid_v[0]),
        .rk_ready(rk_ready_v[0]), .rk_data(rk_data_v[0]), .rk_round(rk_round_v[0]),
        .done(done_v[0]));

    aes_key_schedule #(.KEY_BITS(192)) u_k192 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .key_in(key_r[1][255:64]),
        .inv_mode(inv_v[1]), .busy(busy_v[1]), .rk_valid(rk_valid_v[1]),
        .rk_ready(rk_ready_v[1]), .rk_data(rk_data_v[1]), .rk_round(rk_round_v[1]),
        .done(done_v[1]));

    aes_key_schedule #(.KEY_BITS(256)) u_k256 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .key_in(key_r[2]),
        .inv_mode(inv_v[2]), .busy(busy_v[2]), .rk_valid(rk_valid_v[2]),
        .rk_ready(rk_ready_v[2]), .rk_data(rk_data_v[2]), .rk_round(rk_round_v[2]),
        .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KEY128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K128_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] KEY192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192_R1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] K192_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] KEY256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] KEY128B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K128B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    int checks = 0;
    int errors = 0;

    // Results of the most recent capture run.
    logic [127:0] got [15];
    int first_valid, done_cycle, hs_count, order_bad, stall_bad;
    int first_hs_round, last_hs_round;
    logic busy_c1, done_busy;

    // Starts a run (unless already started by a chained done cycle), then
    // collects round keys until done. Cycle 1 is the cycle after the start edge.
    task automatic capture(input int s, input bit inv, input bit rnd, input bit pre,
                           input int poke, input bit chain,
                           input logic [255:0] next_key, input bit next_inv);
        int cycle, expect_r, nr_s;
        bit stalled;
        logic [127:0] pd;
        logic [3:0] pr;
        nr_s = (s == 0) ? 10 : (s == 1) ? 12 : 14;
        for (int i = 0; i < 15; i++) got[i] = '0;
        first_valid = -1; done_cycle = -1; hs_count = 0; order_bad = 0; stall_bad = 0;
        first_hs_round = -1; last_hs_round = -1; done_busy = 1'bx;
        if (!pre) begin
            @(negedge clk);
            inv_v[s] = inv;
            start_v[s] = 1'b1;
        end
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        cycle = 1;
        busy_c1 = busy_v[s];
        expect_r = inv ? nr_s : 0;
        stalled = 1'b0;
        pd = '0; pr = '0;
        while (cycle <= 200) begin
            if (poke != 0 && cycle == poke)     start_v[s] = 1'b1;
            if (poke != 0 && cycle == poke + 1) start_v[s] = 1'b0;
            if (stalled && (rk_valid_v[s] !== 1'b1 || rk_data_v[s] !== pd || rk_round_v[s] !== pr))
                stall_bad++;
            if (done_v[s] === 1'b1) begin
                done_cycle = cycle;
                done_busy = busy_v[s];
                if (chain) begin
                    key_r[s] = next_key;
                    inv_v[s] = next_inv;
                    start_v[s] = 1'b1;
                end
                break;
            end
            rk_ready_v[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid_v[s] === 1'b1) begin
                if (first_valid < 0) first_valid = cycle;
                if (rk_ready_v[s]) begin
                    if (int'(rk_round_v[s]) != expect_r) order_bad++;
                    if (rk_round_v[s] < 4'd15) got[rk_round_v[s]] = rk_data_v[s];
                    if (first_hs_round < 0) first_hs_round = int'(rk_round_v[s]);
                    last_hs_round = int'(rk_round_v[s]);
                    hs_count++;
                    expect_r = inv ? expect_r - 1 : expect_r + 1;
                end
                stalled = !rk_ready_v[s];
                pd = rk_data_v[s];
                pr = rk_round_v[s];
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            cycle++;
        end
        rk_ready_v[s] = 1'b1;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            rst_v[s] = 1'b1; start_v[s] = 1'b0; inv_v[s] = 1'b0; rk_ready_v[s] = 1'b1;
            key_r[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++; if (busy_v[s] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", s, busy_v[s]); end
            checks++; if (rk_valid_v[s] !== 1'b0) begin errors++; $display("FAIL reset_rk_valid[%0d]: got %b expected 0", s, rk_valid_v[s]); end
            checks++; if (rk_data_v[s] !== 128'h0) begin errors++; $display("FAIL reset_rk_data[%0d]: got %h expected 0", s, rk_data_v[s]); end
            checks++; if (rk_round_v[s] !== 4'h0) begin errors++; $display("FAIL reset_rk_round[%0d]: got %h expected 0", s, rk_round_v[s]); end
            checks++; if (done_v[s] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", s, done_v[s]); end
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) rst_v[s] = 1'b0;
    endtask

    task automatic test_aes128_fwd();
        key_r[0] = {KEY128, 128'h0};
        capture(0, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
        checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL f128_busy_c1: got %b expected 1", busy_c1); end
        checks++; if (first_valid != 41) begin errors++; $display("FAIL f128_first_valid: got %0d expected 41", first_valid); end
        checks++; if (done_cycle != 52) begin errors++; $display("FAIL f128_done_cycle: got %0d expected 52", done_cycle); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL f128_done_busy: got %b expected 0", done_busy); end
        checks++; if (hs_count != 11) begin errors++; $display("FAIL f128_hs_count: got %0d expected 11", hs_count); end
        checks++; if (order_bad != 0) begin errors++; $display("FAIL f128_order: got %0d expected 0", order_bad); end
        checks++; if (got[0] !== KEY128) begin errors++; $display("FAIL f128_r0: got %h expected %h", got[0], KEY128); end
        checks++; if (got[1] !== K128_R1) begin errors++; $display("FAIL f128_r1: got %h expected %h", got[1], K128_R1); end
        checks++; if (got[10] !== K128_R10) begin errors++; $display("FAIL f128_r10: got %h expected %h", got[10], K128_R10); end
    endtask

    task automatic test_aes128_inv_stall();
        key_r[0] = {KEY128, 128'h0};
        capture(0, 1'b1, 1'b1, 1'b0, 0, 1'b0, '0, 1'b0);
        checks++; if (first_valid != 41) begin errors++; $display("FAIL i128_first_valid: got %0d expected 41", first_valid); end
        checks++; if (hs_count != 11) begin errors++; $display("FAIL i128_hs_count: got %0d expected 11", hs_count); end
        checks++; if (order_bad != 0) begin errors++; $display("FAIL i128_order: got %0d expected 0", order_bad); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL i128_stall_stable: got %0d expected 0", stall_bad); end
        checks++; if (first_hs_round != 10) begin errors++; $display("FAIL i128_first_round: got %0d expected 10", first_hs_round); end
        checks++; if (last_hs_round != 0) begin errors++; $display("FAIL i128_last_round: got %0d expected 0", last_hs_round); end
        checks++; if (got[10] !== K128_R10) begin errors++; $display("FAIL i128_r10: got %h expected %h", got[10], K128_R10); end
        checks++; if (got[0] !== KEY128) begin errors++; $display("FAIL i128_r0: got %h expected %h", got[0], KEY128); end
        checks++; if (done_cycle < 0) begin errors++; $display("FAIL i128_done: got timeout expected done pulse"); end
    endtask

    task automatic test_aes192();
        key_r[1] = {KEY192, 64'h0};
        capture(1, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
        checks++; if (first_valid != 47) begin errors++; $display("FAIL f192_first_valid: got %0d expected 47", first_valid); end
        checks++; if (done_cycle != 60) begin errors++; $display("FAIL f192_done_cycle: got %0d expected 60", done_cycle); end
        checks++; if (got[0] !== KEY192[191:64]) begin errors++; $display("FAIL f192_r0: got %h expected %h", got[0], KEY192[191:64]); end
        checks++; if (got[1] !== K192_R1) begin errors++; $display("FAIL f192_r1: got %h expected %h", got[1], K192_R1); end
        checks++; if (got[12] !== K192_R12) begin errors++; $display("FAIL f192_r12: got %h expected %h", got[12], K192_R12); end
    endtask

    task automatic test_aes256();
        key_r[2] = KEY256;
        capture(2, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
        checks++; if (first_valid != 53) begin errors++; $display("FAIL f256_first_valid: got %0d expected 53", first_valid); end
        checks++; if (done_cycle != 68) begin errors++; $display("FAIL f256_done_cycle: got %0d expected 68", done_cycle); end
        checks++; if (got[1] !== KEY256[127:0]) begin errors++; $display("FAIL f256_r1: got %h expected %h", got[1], KEY256[127:0]); end
        checks++; if (got[14] !== K256_R14) begin errors++; $display("FAIL f256_r14: got %h expected %h", got[14], K256_R14); end
    endtask

    task automatic test_start_while_busy();
        key_r[0] = {KEY128, 128'h0};
        capture(0, 1'b0, 1'b0, 1'b0, 10, 1'b0, '0, 1'b0);
        checks++; if (first_valid != 41) begin errors++; $display("FAIL poke_first_valid: got %0d expected 41", first_valid); end
        checks++; if (done_cycle != 52) begin errors++; $display("FAIL poke_done_cycle: got %0d expected 52", done_cycle); end
        checks++; if (got[10] !== K128_R10) begin errors++; $display("FAIL poke_r10: got %h expected %h", got[10], K128_R10); end
    endtask

    task automatic test_reset_mid_run();
        int cycle;
        int bad_done;
        key_r[0] = {KEY128B, 128'h0};
        @(negedge clk);
        inv_v[0] = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        cycle = 1;
        while (cycle < 20) begin
            @(posedge clk); #1;
            cycle++;
        end
        rst_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        start_v[0] = 1'b0;
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_v[0]); end
        checks++; if (rk_data_v[0] !== 128'h0) begin errors++; $display("FAIL rstmid_rk_data: got %h expected 0", rk_data_v[0]); end
        checks++; if (rk_round_v[0] !== 4'h0) begin errors++; $display("FAIL rstmid_rk_round: got %h expected 0", rk_round_v[0]); end
        bad_done = 0;
        repeat (40) begin
            if (done_v[0] !== 1'b0 || rk_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad_done++;
            @(posedge clk); #1;
        end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad_done); end
        capture(0, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
        checks++; if (first_valid != 41) begin errors++; $display("FAIL rstmid_restart_first_valid: got %0d expected 41", first_valid); end
        checks++; if (got[0] !== KEY128B) begin errors++; $display("FAIL rstmid_restart_r0: got %h expected %h", got[0], KEY128B); end
        checks++; if (got[10] !== K128B_R10) begin errors++; $display("FAIL rstmid_restart_r10: got %h expected %h", got[10], K128B_R10); end
    endtask

    task automatic test_back_to_back();
        key_r[0] = {KEY128, 128'h0};
        capture(0, 1'b0, 1'b0, 1'b0, 0, 1'b1, {KEY128B, 128'h0}, 1'b0);
        checks++; if (done_cycle != 52) begin errors++; $display("FAIL b2b_first_done: got %0d expected 52", done_cycle); end
        checks++; if (got[10] !== K128_R10) begin errors++; $display("FAIL b2b_first_r10: got %h expected %h", got[10], K128_R10); end
        capture(0, 1'b0, 1'b0, 1'b1, 0, 1'b0, '0, 1'b0);
        checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL b2b_busy_c1: got %b expected 1", busy_c1); end
        checks++; if (first_valid != 41) begin errors++; $display("FAIL b2b_first_valid: got %0d expected 41", first_valid); end
        checks++; if (got[0] !== KEY128B) begin errors++; $display("FAIL b2b_r0: got %h expected %h", got[0], KEY128B); end
        checks++; if (got[10] !== K128B_R10) begin errors++; $display("FAIL b2b_r10: got %h expected %h", got[10], K128B_R10); end
        checks++; if (done_cycle != 52) begin errors++; $display("FAIL b2b_done: got %0d expected 52", done_cycle); end
    endtask

    initial begin
        test_reset();
        test_aes128_fwd();
        test_aes128_inv_stall();
        test_aes192();
        test_aes256();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, parametrised AES key-schedule engine supporting 128/192/256-bit keys and both round-key orders. It sits beside the cipher and inverse-cipher datapaths and supersedes the per-round combinational key-expansion logic. A loaded key is expanded one 32-bit word per cycle into an internal word buffer. Round keys are then streamed out over a valid/ready handshake, ascending for encryption or descending for decryption.

## Interface
- KEY_BITS, 128, key length; legal values 128, 192 and 256; any other value is an elaboration error.
- NK, KEY_BITS/32, derived localparam.
- NR, NK+6, derived localparam; number of rounds.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  load request; sampled only in IDLE.
- key_in  input  KEY_BITS  cipher key; word w0 = key_in[KEY_BITS-1 -: 32], MSB-first.
- inv_mode  input  1  0: emit rounds 0..NR; 1: emit rounds NR..0; sampled with start.
- busy  output  1  high in every state except IDLE.
- rk_valid  output  1  rk_data/rk_round hold a round key.
- rk_ready  input  1  consumer accepts the round key this cycle.
- rk_data  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] in [127:96].
- rk_round  output  4  round index r of rk_data.
- done  output  1  one-cycle pulse after the final round key handshake.

## Operation
- States: IDLE, EXPAND, OUTPUT.
- IDLE with start=1:
  - Write key words w0..w(NK-1) to the buffer.
  - Set word index i=NK and rcon=0x01.
  - Latch inv_mode.
  - Go to EXPAND.
- start in any other state is ignored.
- EXPAND computes one word per cycle for i = NK .. 4(NR+1)-1:
  - temp = w[i-1].
  - If i mod NK = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), where xtime is a left shift with conditional XOR 0x1b.
  - Else if NK=8 and i mod NK = 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
- RotWord is a left rotation by one byte. SubWord applies Sbox bytewise.
- Leave EXPAND after the word at i = 4(NR+1)-1 is written. This takes E = 4(NR+1)-NK cycles: 40, 46 and 52 for the three key sizes.
- Entering OUTPUT: r = 0 (forward) or r = NR (inverse); rk_valid = 1.
- On each cycle with rk_valid & rk_ready: step r (+1 forward, -1 inverse).
- Final handshake (r = NR forward, r = 0 inverse): go to IDLE, drop rk_valid, pulse done next cycle.
- The buffer holds 4(NR+1) words (max 60). It is not cleared between keys. A fresh start fully overwrites every word that is read.

## Timing
- Reset values: busy=0, rk_valid=0, rk_data=0, rk_round=0, done=0, state=IDLE.
- rst mid-EXPAND or mid-OUTPUT:
  - Abort at the next edge; no done pulse.
  - The partially streamed key is lost.
  - start in the same cycle as rst is ignored.
- Start accepted at edge 0, busy=1 from cycle 1. First rk_valid at cycle E+1: 41, 47 or 53.
- Handshake rules:
  - rk_data and rk_round are registered.
  - While rk_valid=1 and rk_ready=0 they hold stable.
  - rk_valid never drops before a handshake.
  - With rk_ready tied high, one round key per cycle; NR+1 cycles of rk_valid.
- done is asserted in the cycle after the last handshake, together with busy=0. A start in that same cycle is accepted.
- rk_ready is ignored when rk_valid=0.

## Structure
- Shared package aes_pkg holds:
  - localparam functions nk(key_bits) and nr(key_bits);
  - function xtime(byte);
  - the state enum type.
- Sub-module Sbox (existing, 8-bit data_in/data_out) is instantiated 4× on the SubWord path.
- A mux selects RotWord'd or plain w[i-1] as the Sbox input.
- The word buffer is a flat register array with no RAM macro. It has one write port in EXPAND. It has four read ports for rk_data, which are registered on each advance.

## Test plan
- AES-128 forward:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
  - Round 0 = the key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - First rk_valid at cycle 41; done at cycle 52.
- AES-128 inverse with the same key:
  - First output rk_round=10 = d014f9a8…b6630ca6; last output rk_round=0 = the key.
  - Randomly toggle rk_ready; check data stays stable while stalled and there are no skipped or repeated rounds.
- AES-192 (KEY_BITS=192):
  - Key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
  - First rk_valid at cycle 47.
- AES-256 (KEY_BITS=256):
  - Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Round 14 = fe4890d1e6188d0b046df344706c631e; exercises the i mod 8 = 4 SubWord path.
- Reset mid-run and start while busy:
  - Pulse start during EXPAND: no effect.
  - Assert rst at cycle 20: all outputs 0 next cycle and no done.
  - A new start then gives correct round keys.
- Back-to-back:
  - Assert start in the done cycle with a second key.
  - It is accepted; the second key's round 0 appears at the correct latency.
